// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the iterative multiply/divide unit:
//               opcode encodings, FSM state codes, step modes, defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // OpE encodings: bit 1 selects divide, bit 0 selects unsigned
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Iteration-step modes
    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } stepMode_e;

    localparam int ITERS_DEFAULT = 32;

    // Quotient produced by a divide by zero (restoring divide always subtracts)
    localparam logic [ITERS_DEFAULT-1:0] DIV0_QUOT = '1;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               MUL: radix-2 shift-add; low half holds the remaining
//                    multiplier bits, high half the partial product.
//               DIV: restoring shift-subtract; high half is the partial
//                    remainder, low half shifts dividend out / quotient in.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               mode,
    input  logic [2*WIDTH-1:0] accIn,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] accOut
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Compute both candidate next accumulators and select by mode
    always_comb begin
        w_sum  = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
        w_rem  = accIn[2*WIDTH-1:WIDTH-1];
        w_ge   = (w_rem >= {1'b0, operand});
        w_diff = w_rem - {1'b0, operand};
        if (mode == MODE_DIV) begin
            accOut = {(w_ge ? w_diff[WIDTH-1:0] : w_rem[WIDTH-1:0]), accIn[WIDTH-2:0], w_ge};
        end else begin
            accOut = {w_sum, accIn[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO. Operates on
//               magnitudes for ITERS cycles, then applies signs in one FIX
//               cycle. Busy requests pipeline stalls while in flight.
//               Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITERS_DEFAULT,
    parameter int ITERS = ITERS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StartE,
    input  logic             StallE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             WriteHIE,
    input  logic             WriteLOE,
    input  logic [WIDTH-1:0] WDataE,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_busy;
    logic               w_start;
    logic               w_mtOk;
    logic               w_isSigned;
    logic               w_opDiv;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [2*WIDTH-1:0] w_accNext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_remd;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;
    logic               w_fastMul;
    logic [2*WIDTH-1:0] w_fastProd;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_start    = StartE & ~StallE & ~w_busy & ~Cancel;
    // A start in the same cycle wins over MTHI/MTLO
    assign w_mtOk     = ~StallE & ~w_busy & ~w_start;
    assign w_isSigned = ~OpE[0];
    assign w_opDiv    = OpE[1];
    assign w_magA     = (w_isSigned && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign w_magB     = (w_isSigned && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fastMag;
    assign w_fastMul  = w_start & ~w_opDiv;
    assign w_fastMag  = {{WIDTH{1'b0}}, w_magA} * {{WIDTH{1'b0}}, w_magB};
    assign w_fastProd = (w_isSigned && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1])) ? -w_fastMag : w_fastMag;
`else
    assign w_fastMul  = 1'b0;
    assign w_fastProd = '0;
`endif

    muldiv_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .mode    (r_isDiv),
        .accIn   (r_acc),
        .operand (r_operand),
        .accOut  (w_accNext)
    );

    // Sign fix-up of the magnitude result, used in the FIX cycle
    always_comb begin
        w_prod = r_negRes ? -r_acc : r_acc;
        w_quot = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_remd = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        if (r_isDiv) begin
            w_fixHi = w_remd;
            w_fixLo = w_quot;
        end else begin
            w_fixHi = w_prod[2*WIDTH-1:WIDTH];
            w_fixLo = w_prod[WIDTH-1:0];
        end
    end

    // Sequencer, working registers and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fastMul) begin
                        r_hi   <= w_fastProd[2*WIDTH-1:WIDTH];
                        r_lo   <= w_fastProd[WIDTH-1:0];
                        r_done <= 1'b1;
                    end else if (w_start) begin
                        r_acc     <= {{WIDTH{1'b0}}, w_magA};
                        r_operand <= w_magB;
                        r_isDiv   <= w_opDiv;
                        r_negRes  <= w_isSigned & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                        r_negRem  <= w_isSigned & SrcAE[WIDTH-1];
                        r_count   <= CNT_W'(ITERS - 1);
                        r_state   <= ST_RUN;
                    end else if (w_mtOk) begin
                        if (WriteHIE) r_hi <= WDataE;
                        if (WriteLOE) r_lo <= WDataE;
                    end
                end
                ST_RUN: begin
                    if (Cancel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc   <= w_accNext;
                        r_count <= r_count - 1'b1;
                        if (r_count == '0) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    if (!Cancel) begin
                        r_hi   <= w_fixHi;
                        r_lo   <= w_fixLo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Busy = w_busy;
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule : muldiv_unit
`default_nettype wire
